// File: rtl/gouram_datatypes.sv
// Shared trace types for the gouram tracker chain.
// if_trace_t is the element handed from if_tracker to validity_filter.
package gouram_datatypes;

    typedef struct packed {
        logic [31:0] instruction;
        logic [31:0] addr;
        integer      if_start;
        integer      if_gnt;
        integer      if_end;
    } if_trace_t;

    localparam int IF_TRACE_W = $bits(if_trace_t);

    // What the fetch queue remembers between grant and response.
    typedef struct packed {
        logic [31:0] addr;
        integer      if_start;
        integer      if_gnt;
    } fetch_entry_t;

    localparam int FETCH_ENTRY_W = $bits(fetch_entry_t);

    typedef enum logic {
        REQ_IDLE,
        REQ_WAIT
    } req_state_t;

endpackage

// File: rtl/fetch_pending_queue.sv
// In-order queue of granted fetches awaiting their response; head is readable combinationally.
// Latency: pushed entry is visible at the head the cycle after the push.
// Backpressure: none; push at full without a pop is dropped, pop while full is allowed.
module fetch_pending_queue #(
    parameter int DEPTH = 4,
    parameter int W     = 96,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  pop_data,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    // At full a simultaneous pop frees the head slot, which is exactly where wr_ptr points.
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/if_tracker.sv
// Instruction-fetch tracker: one timestamped trace element per completed OBI fetch.
// Latency: rvalid -> if_data_ready_o pulse is 1 cycle.
// Backpressure: none; downstream must accept every pulse.
import gouram_datatypes::*;

module if_tracker #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  integer                               counter,
    input  logic                                 instr_req_i,
    input  logic                                 instr_gnt_i,
    input  logic [ADDR_WIDTH-1:0]                instr_addr_i,
    input  logic                                 instr_rvalid_i,
    input  logic [DATA_WIDTH-1:0]                instr_rdata_i,
    output if_trace_t                            if_data_o,
    output integer                               if_stage_end_o,
    output logic                                 if_data_ready_o,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] pending_o,
    output logic                                 overflow_o,
    output logic                                 orphan_o
);

    req_state_t   state;
    req_state_t   state_n;
    logic [31:0]  lat_addr;
    integer       lat_start;
    logic         push;
    fetch_entry_t push_entry;
    fetch_entry_t pop_entry;
    logic         q_full;
    logic         q_empty;
    logic         pop_ok;

    fetch_pending_queue #(
        .DEPTH (MAX_OUTSTANDING),
        .W     (FETCH_ENTRY_W)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (instr_rvalid_i),
        .pop_data  (pop_entry),
        .full      (q_full),
        .empty     (q_empty),
        .count     (pending_o)
    );

    // A response never belongs to a fetch granted in the same cycle, so gate on registered empty.
    assign pop_ok = instr_rvalid_i && !q_empty;

    always_comb begin
        state_n    = state;
        push       = 1'b0;
        push_entry = '0;
        case (state)
            REQ_IDLE: begin
                if (instr_req_i && instr_gnt_i) begin
                    push       = 1'b1;
                    push_entry = '{addr: 32'(instr_addr_i), if_start: counter, if_gnt: counter};
                end else if (instr_req_i) begin
                    state_n = REQ_WAIT;
                end
            end
            REQ_WAIT: begin
                if (instr_gnt_i) begin
                    push       = 1'b1;
                    push_entry = '{addr: lat_addr, if_start: lat_start, if_gnt: counter};
                    state_n    = REQ_IDLE;
                end else if (!instr_req_i) begin
                    state_n = REQ_IDLE;
                end
            end
            default: state_n = REQ_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= REQ_IDLE;
            lat_addr  <= '0;
            lat_start <= 0;
        end else begin
            state <= state_n;
            if (state == REQ_IDLE && instr_req_i && !instr_gnt_i) begin
                lat_addr  <= 32'(instr_addr_i);
                lat_start <= counter;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            if_data_o       <= '0;
            if_stage_end_o  <= 0;
            if_data_ready_o <= 1'b0;
            overflow_o      <= 1'b0;
            orphan_o        <= 1'b0;
        end else begin
            if_data_ready_o <= pop_ok;
            if (pop_ok) begin
                if_data_o <= '{instruction: 32'(instr_rdata_i),
                               addr:        pop_entry.addr,
                               if_start:    pop_entry.if_start,
                               if_gnt:      pop_entry.if_gnt,
                               if_end:      counter};
                if_stage_end_o <= counter;
            end
            if (push && q_full && !pop_ok) overflow_o <= 1'b1;
            if (instr_rvalid_i && q_empty) orphan_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_if_tracker.sv
// Directed bench for if_tracker: a free-running counter timestamps every cycle,
// inputs change 1 time unit after each rising edge and outputs are sampled there too.
import gouram_datatypes::*;

module tb_if_tracker;

    logic        clk = 1'b0;
    logic        rst;
    integer      counter = 0;
    logic        instr_req_i;
    logic        instr_gnt_i;
    logic [31:0] instr_addr_i;
    logic        instr_rvalid_i;
    logic [31:0] instr_rdata_i;
    if_trace_t   if_data_o;
    integer      if_stage_end_o;
    logic        if_data_ready_o;
    logic [2:0]  pending_o;
    logic        overflow_o;
    logic        orphan_o;

    int n_cmp  = 0;
    int n_fail = 0;

    if_tracker #(
        .MAX_OUTSTANDING (4),
        .ADDR_WIDTH      (32),
        .DATA_WIDTH      (32)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .counter         (counter),
        .instr_req_i     (instr_req_i),
        .instr_gnt_i     (instr_gnt_i),
        .instr_addr_i    (instr_addr_i),
        .instr_rvalid_i  (instr_rvalid_i),
        .instr_rdata_i   (instr_rdata_i),
        .if_data_o       (if_data_o),
        .if_stage_end_o  (if_stage_end_o),
        .if_data_ready_o (if_data_ready_o),
        .pending_o       (pending_o),
        .overflow_o      (overflow_o),
        .orphan_o        (orphan_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) counter <= counter + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int n);
        int guard = 0;
        while (counter != n && guard < 200) begin
            step();
            guard++;
        end
        chk("sync_counter", counter, n);
    endtask

    task automatic chk_out(input string tag, input logic [31:0] ins, input logic [31:0] addr,
                           input int st, input int gn, input int en);
        chk({tag, "_ready"}, {31'd0, if_data_ready_o}, 32'd1);
        chk({tag, "_instr"}, if_data_o.instruction, ins);
        chk({tag, "_addr"},  if_data_o.addr, addr);
        chk({tag, "_start"}, if_data_o.if_start, st);
        chk({tag, "_gnt"},   if_data_o.if_gnt, gn);
        chk({tag, "_end"},   if_data_o.if_end, en);
        chk({tag, "_stage_end"}, if_stage_end_o, en);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_data_instr"}, if_data_o.instruction, 0);
        chk({tag, "_data_addr"},  if_data_o.addr, 0);
        chk({tag, "_data_end"},   if_data_o.if_end, 0);
        chk({tag, "_stage_end"},  if_stage_end_o, 0);
        chk({tag, "_ready"},      {31'd0, if_data_ready_o}, 0);
        chk({tag, "_pending"},    {29'd0, pending_o}, 0);
        chk({tag, "_overflow"},   {31'd0, overflow_o}, 0);
        chk({tag, "_orphan"},     {31'd0, orphan_o}, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst            = 1'b1;
        instr_req_i    = 1'b0;
        instr_gnt_i    = 1'b0;
        instr_addr_i   = '0;
        instr_rvalid_i = 1'b0;
        instr_rdata_i  = '0;
        step();
        step();
        rst = 1'b0;
        chk_all_zero("reset");

        // Single fetch: grant in the request cycle.
        wait_to(10);
        instr_req_i = 1'b1; instr_gnt_i = 1'b1; instr_addr_i = 32'h80;
        step();
        instr_req_i = 1'b0; instr_gnt_i = 1'b0;
        chk("single_pending", {29'd0, pending_o}, 1);
        wait_to(12);
        instr_rvalid_i = 1'b1; instr_rdata_i = 32'h0000_2083;
        step();
        instr_rvalid_i = 1'b0;
        chk_out("single", 32'h2083, 32'h80, 10, 10, 12);
        chk("single_pending_after", {29'd0, pending_o}, 0);
        step();
        chk("single_one_pulse", {31'd0, if_data_ready_o}, 0);

        // Grant stall: request seen at 20, granted at 23.
        wait_to(20);
        instr_req_i = 1'b1; instr_addr_i = 32'h100;
        step();
        step();
        step();
        instr_gnt_i = 1'b1;
        step();
        instr_req_i = 1'b0; instr_gnt_i = 1'b0;
        instr_rvalid_i = 1'b1; instr_rdata_i = 32'h13;
        step();
        instr_rvalid_i = 1'b0;
        chk_out("stall", 32'h13, 32'h100, 20, 23, 24);
        step();
        chk("stall_one_pulse", {31'd0, if_data_ready_o}, 0);

        // Pipelined fetches: grants 30..32, responses 31..33.
        wait_to(30);
        instr_req_i = 1'b1; instr_gnt_i = 1'b1; instr_addr_i = 32'h0;
        step();
        chk("pipe_pending_31", {29'd0, pending_o}, 1);
        chk("pipe_noready_31", {31'd0, if_data_ready_o}, 0);
        instr_addr_i = 32'h4; instr_rvalid_i = 1'b1; instr_rdata_i = 32'hA0;
        step();
        chk_out("pipe0", 32'hA0, 32'h0, 30, 30, 31);
        chk("pipe_pending_32", {29'd0, pending_o}, 1);
        instr_addr_i = 32'h8; instr_rdata_i = 32'hA1;
        step();
        chk_out("pipe1", 32'hA1, 32'h4, 31, 31, 32);
        chk("pipe_pending_33", {29'd0, pending_o}, 1);
        instr_req_i = 1'b0; instr_gnt_i = 1'b0; instr_rdata_i = 32'hA2;
        step();
        instr_rvalid_i = 1'b0;
        chk_out("pipe2", 32'hA2, 32'h8, 32, 32, 33);
        chk("pipe_pending_34", {29'd0, pending_o}, 0);

        // Overflow: five grants into a four-deep queue.
        wait_to(40);
        instr_req_i = 1'b1; instr_gnt_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            instr_addr_i = 32'h200 + 32'(4 * i);
            step();
        end
        instr_req_i = 1'b0; instr_gnt_i = 1'b0;
        chk("ovf_pending", {29'd0, pending_o}, 4);
        chk("ovf_flag", {31'd0, overflow_o}, 1);
        chk("ovf_noready", {31'd0, if_data_ready_o}, 0);
        for (int i = 0; i < 4; i++) begin
            instr_rvalid_i = 1'b1; instr_rdata_i = 32'h1000 + 32'(i);
            step();
            chk_out("ovf_drain", 32'h1000 + 32'(i), 32'h200 + 32'(4 * i), 40 + i, 40 + i, 45 + i);
        end
        instr_rvalid_i = 1'b0;
        chk("ovf_pending_drained", {29'd0, pending_o}, 0);
        chk("ovf_sticky", {31'd0, overflow_o}, 1);

        // Orphan response, then reset clears everything.
        wait_to(52);
        instr_rvalid_i = 1'b1; instr_rdata_i = 32'hDEAD;
        step();
        instr_rvalid_i = 1'b0;
        chk("orphan_noready", {31'd0, if_data_ready_o}, 0);
        chk("orphan_flag", {31'd0, orphan_o}, 1);
        step();
        chk("orphan_sticky", {31'd0, orphan_o}, 1);
        chk("orphan_noready2", {31'd0, if_data_ready_o}, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_all_zero("post_rst");

        // Reset mid-flight drops both pending fetches.
        wait_to(60);
        instr_req_i = 1'b1; instr_gnt_i = 1'b1; instr_addr_i = 32'h300;
        step();
        instr_addr_i = 32'h304;
        step();
        instr_req_i = 1'b0; instr_gnt_i = 1'b0;
        chk("mid_pending", {29'd0, pending_o}, 2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_pending_rst", {29'd0, pending_o}, 0);
        instr_rvalid_i = 1'b1; instr_rdata_i = 32'h77;
        step();
        chk("mid_noready1", {31'd0, if_data_ready_o}, 0);
        chk("mid_orphan", {31'd0, orphan_o}, 1);
        step();
        instr_rvalid_i = 1'b0;
        chk("mid_noready2", {31'd0, if_data_ready_o}, 0);
        chk("mid_pending_end", {29'd0, pending_o}, 0);

        // Push and pop together at full: no overflow, pointers wrap.
        wait_to(70);
        instr_req_i = 1'b1; instr_gnt_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            instr_addr_i = 32'h400 + 32'(4 * i);
            step();
        end
        chk("full_pending", {29'd0, pending_o}, 4);
        instr_addr_i = 32'h410; instr_rvalid_i = 1'b1; instr_rdata_i = 32'h50;
        step();
        instr_req_i = 1'b0; instr_gnt_i = 1'b0;
        chk_out("full_pp", 32'h50, 32'h400, 70, 70, 74);
        chk("full_pp_pending", {29'd0, pending_o}, 4);
        chk("full_pp_no_ovf", {31'd0, overflow_o}, 0);
        for (int i = 1; i < 5; i++) begin
            instr_rvalid_i = 1'b1; instr_rdata_i = 32'h50 + 32'(i);
            step();
            chk_out("wrap_drain", 32'h50 + 32'(i), 32'h400 + 32'(4 * i), 70 + i, 70 + i, 74 + i);
        end
        instr_rvalid_i = 1'b0;
        chk("wrap_pending_end", {29'd0, pending_o}, 0);
        chk("wrap_no_ovf", {31'd0, overflow_o}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
